pixel_plot_sink: RTL



---
 rtl/pixel_plot_sink.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pixel_plot_sink.sv
// Plot request sink: range-checks and queues {addr, colour} plot requests, drains them to a
// valid/ready framebuffer write port, and runs a full-screen background clear sweep on request.
module pixel_plot_sink #(
    parameter int          DEPTH     = 4,
    parameter int          WIDTH     = 160,
    parameter int          HEIGHT    = 120,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        plot,
    input  logic [7:0]  in_x,
    input  logic [6:0]  in_y,
    input  logic [2:0]  in_colour,
    input  logic        clear_req,
    input  logic        fb_ready,
    output logic        fb_we,
    output logic [14:0] fb_addr,
    output logic [2:0]  fb_data,
    output logic        busy,
    output logic [2:0]  fill_level,
    output logic        overflow,
    output logic        range_err
);

    localparam int          PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [14:0] LAST_ADDR = 15'(WIDTH * HEIGHT - 1);
    localparam logic [7:0]  X_LIM     = 8'(WIDTH);
    localparam logic [6:0]  Y_LIM     = 7'(HEIGHT);
    localparam logic [2:0]  FULL      = 3'(DEPTH);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t          state_q, state_d;
    logic            pend_q, pend_d;
    logic [14:0]     sweep_q, sweep_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [2:0]      count_q, count_d;
    logic            we_q, we_d;
    logic [14:0]     addr_q, addr_d;
    logic [2:0]      data_q, data_d;
    logic            ovf_q, ovf_d;
    logic            rerr_q, rerr_d;
    logic [17:0]     mem_q [DEPTH];

    logic            in_range;
    logic [14:0]     req_addr;
    logic            pop;
    logic            push;
    logic            out_free;
    logic            busy_w;
    logic [2:0]      remaining;
    logic [17:0]     head_next;

    assign in_range  = (in_x < X_LIM) && (in_y < Y_LIM);
    assign req_addr  = 15'(in_y) * 15'(WIDTH) + 15'(in_x);
    // The head entry stays queued while it is on the write port; it leaves on completion.
    assign pop       = (state_q == S_IDLE) && we_q && fb_ready;
    assign push      = plot && in_range && ((count_q != FULL) || pop);
    assign out_free  = !we_q || fb_ready;
    assign busy_w    = pend_q || (state_q == S_CLEAR);
    assign remaining = count_q - {2'b00, pop};
    assign head_next = pop ? mem_q[rd_ptr_q + PW'(1)] : mem_q[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        sweep_d  = sweep_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        we_d     = we_q;
        addr_d   = addr_q;
        data_d   = data_q;
        ovf_d    = ovf_q;
        rerr_d   = rerr_q;
        count_d  = count_q + {2'b00, push} - {2'b00, pop};

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (plot && !in_range) rerr_d = 1'b1;
        if (plot && in_range && (count_q == FULL) && !pop) ovf_d = 1'b1;
        if (clear_req && !busy_w) pend_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (out_free) begin
                    if (pend_q) begin
                        state_d = S_CLEAR;
                        sweep_d = '0;
                        we_d    = 1'b1;
                        addr_d  = '0;
                        data_d  = BG_COLOUR;
                    end else if (remaining != 3'd0) begin
                        we_d             = 1'b1;
                        {addr_d, data_d} = head_next;
                    end else if (push) begin
                        // Empty queue: present the incoming request directly for one-cycle latency.
                        we_d   = 1'b1;
                        addr_d = req_addr;
                        data_d = in_colour;
                    end else begin
                        we_d = 1'b0;
                    end
                end
            end
            S_CLEAR: begin
                if (fb_ready) begin
                    if (sweep_q == LAST_ADDR) begin
                        state_d = S_IDLE;
                        pend_d  = 1'b0;
                        we_d    = 1'b0;
                    end else begin
                        sweep_d = sweep_q + 15'd1;
                        addr_d  = sweep_q + 15'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            pend_q   <= 1'b0;
            sweep_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            sweep_q  <= sweep_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            rerr_q   <= rerr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_addr, in_colour};
    end

    assign fb_we      = we_q;
    assign fb_addr    = addr_q;
    assign fb_data    = data_q;
    assign busy       = busy_w;
    assign fill_level = count_q;
    assign overflow   = ovf_q;
    assign range_err  = rerr_q;

endmodule
